// File: rtl/sweep_ctrl.sv
// sweep_ctrl: start/stop-bounded, step-sized, dwell-timed frequency sweep sequencer feeding a DDS tuning word.
module sweep_ctrl #(
  parameter int FW = 14,
  parameter int DW = 24
) (
  input  logic          clk_wave,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic          mode,
  input  logic          cont,
  output logic [FW-1:0] freq_word,
  output logic          freq_valid,
  output logic          busy,
  output logic          dir,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] word_q, word_d, start_q, stop_q, step_q;
  logic [DW-1:0] cnt_q, cnt_d, dw_q, dw_in;
  logic valid_q, valid_d, busy_q, dir_q, dir_d, done_q, done_d, err_q, err_d;
  logic mode_q, cont_q, accept;
  logic [FW:0] up_w, dn_w;
  logic [FW-1:0] up_word, dn_word;
  assign dw_in   = (dwell == '0) ? DW'(1) : dwell;
  assign accept  = (state_q == IDLE) && start && !abort && (f_start <= f_stop);
  assign up_w    = {1'b0, word_q} + {1'b0, step_q};
  assign dn_w    = {1'b0, word_q} - {1'b0, step_q};
  assign up_word = (up_w > {1'b0, stop_q}) ? stop_q : up_w[FW-1:0];
  // a borrow means the subtraction wrapped, i.e. it went below f_start
  assign dn_word = (dn_w[FW] || dn_w[FW-1:0] < start_q) ? start_q : dn_w[FW-1:0];
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (f_start > f_stop) err_d = 1'b1;
          else begin
            state_d = RUN_UP;
            word_d  = f_start;
            valid_d = 1'b1;
            dir_d   = 1'b0;
            cnt_d   = dw_in - DW'(1);
          end
        end
      end
      RUN_UP: begin
        if (abort || cnt_q != '0) cnt_d = cnt_q - DW'(1);
        else begin
          cnt_d   = dw_q - DW'(1);
          valid_d = 1'b1;
          if (word_q < stop_q) word_d = up_word;
          else if (start_q == stop_q || !mode_q) begin
            word_d = cont_q ? start_q : '0;
            if (!cont_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
              valid_d = word_q != '0;
            end
          end else begin
            state_d = RUN_DN;
            dir_d   = 1'b1;
            word_d  = dn_word;
          end
        end
      end
      RUN_DN: begin
        if (abort || cnt_q != '0) cnt_d = cnt_q - DW'(1);
        else begin
          cnt_d   = dw_q - DW'(1);
          valid_d = 1'b1;
          if (word_q > start_q) word_d = dn_word;
          else if (cont_q) begin
            state_d = RUN_UP;
            dir_d   = 1'b0;
            word_d  = up_word;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            word_d  = '0;
            valid_d = word_q != '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      word_d  = '0;
      valid_d = word_q != '0;
      dir_d   = 1'b0;
      done_d  = 1'b0;
    end
    if (state_d == IDLE) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end
  end
  always_ff @(posedge clk_wave or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= state_d != IDLE;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk_wave or negedge sys_rst) begin
    if (!sys_rst) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= FW'(1);
      dw_q    <= DW'(1);
      mode_q  <= 1'b0;
      cont_q  <= 1'b0;
    end else if (accept) begin
      start_q <= f_start;
      stop_q  <= f_stop;
      step_q  <= (f_step == '0) ? FW'(1) : f_step;
      dw_q    <= dw_in;
      mode_q  <= mode;
      cont_q  <= cont;
    end
  end
  assign freq_word  = word_q;
  assign freq_valid = valid_q;
  assign busy       = busy_q;
  assign dir        = dir_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed vectors for sweep_ctrl with hand-computed word sequences and timing.
module tb_sweep_ctrl;
  localparam int FW = 14;
  localparam int DW = 24;
  logic clk_wave = 1'b0;
  logic sys_rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, mode = 1'b0, cont = 1'b0;
  logic [FW-1:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [FW-1:0] freq_word;
  logic freq_valid, busy, dir, done, err;
  int n_vec = 0, n_err = 0;
  int exp_w[$];
  int exp_d[$];

  sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk_wave(clk_wave), .sys_rst(sys_rst), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .mode(mode), .cont(cont), .freq_word(freq_word), .freq_valid(freq_valid),
    .busy(busy), .dir(dir), .done(done), .err(err)
  );

  always #5 clk_wave = ~clk_wave;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int s, input int e, input int st, input int dw, input bit m, input bit c);
    f_start = FW'(s);
    f_stop  = FW'(e);
    f_step  = FW'(st);
    dwell   = DW'(dw);
    mode    = m;
    cont    = c;
  endtask

  task automatic pulse_start(input bit with_abort);
    @(negedge clk_wave);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk_wave);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk_wave);
    abort = 1'b1;
    @(posedge clk_wave);
    #1;
    abort = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int gap);
    gap = 0;
    do begin
      @(negedge clk_wave);
      gap++;
    end while (!freq_valid && gap < 200);
    if (!freq_valid) chk({tag, " timeout"}, freq_valid, 1);
  endtask

  // walks exp_w (and exp_d where given); gap to the first word is 1, then d per word
  task automatic run_seq(input string tag, input int d, input bit fin);
    int gap;
    for (int i = 0; i < exp_w.size(); i++) begin
      wait_valid(tag, gap);
      chk($sformatf("%s word[%0d]", tag, i), freq_word, exp_w[i]);
      chk($sformatf("%s gap[%0d]", tag, i), gap, (i == 0) ? 1 : d);
      if (exp_d.size() > i) chk($sformatf("%s dir[%0d]", tag, i), dir, exp_d[i]);
    end
    if (fin) begin
      wait_valid(tag, gap);
      chk({tag, " done gap"}, gap, d);
      chk({tag, " done"}, done, 1);
      chk({tag, " done word"}, freq_word, 0);
      chk({tag, " done busy"}, busy, 0);
      @(negedge clk_wave);
      chk({tag, " done one-shot"}, done, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst word", freq_word, 0);
    chk("rst valid", freq_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst dir", dir, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    @(negedge clk_wave);
    sys_rst = 1'b1;
    repeat (2) @(negedge clk_wave);

    // sawtooth single pass; inputs changed mid-sweep must be ignored
    cfg(10, 40, 10, 3, 0, 0);
    pulse_start(0);
    cfg(0, 1000, 1, 1, 1, 1);
    exp_w = '{10, 20, 30, 40};
    exp_d = '{0, 0, 0, 0};
    run_seq("saw", 3, 1);

    // clamp at f_stop and triangle descent
    cfg(100, 125, 10, 1, 1, 0);
    pulse_start(0);
    exp_w = '{100, 110, 120, 125, 115, 105, 100};
    exp_d = '{0, 0, 0, 0, 1, 1, 1};
    run_seq("tri", 1, 1);
    chk("tri idle valid", freq_valid, 0);

    // continuous sawtooth at full scale with no overflow
    cfg(16380, 16383, 2, 2, 0, 1);
    pulse_start(0);
    exp_w = '{16380, 16382, 16383, 16380, 16382, 16383, 16380};
    exp_d = {};
    run_seq("wrap", 2, 0);
    chk("wrap busy", busy, 1);
    pulse_abort();
    @(negedge clk_wave);
    chk("wrap abort busy", busy, 0);
    chk("wrap abort word", freq_word, 0);

    // bad bounds
    repeat (2) @(negedge clk_wave);
    cfg(50, 20, 1, 1, 0, 0);
    pulse_start(0);
    @(negedge clk_wave);
    chk("bad err", err, 1);
    chk("bad busy", busy, 0);
    chk("bad word", freq_word, 0);
    chk("bad valid", freq_valid, 0);
    @(negedge clk_wave);
    chk("bad err one-shot", err, 0);

    // abort mid-dwell at word 30, then start+abort together
    cfg(10, 40, 10, 5, 0, 0);
    pulse_start(0);
    exp_w = '{10, 20, 30};
    run_seq("abt", 5, 0);
    pulse_abort();
    @(negedge clk_wave);
    chk("abt word", freq_word, 0);
    chk("abt busy", busy, 0);
    chk("abt done", done, 0);
    chk("abt valid", freq_valid, 1);
    pulse_start(1);
    @(negedge clk_wave);
    chk("prio busy", busy, 0);
    chk("prio valid", freq_valid, 0);
    chk("prio err", err, 0);
    repeat (3) @(negedge clk_wave);
    chk("prio busy later", busy, 0);
    chk("prio word later", freq_word, 0);

    // step 0 and dwell 0 act as 1
    cfg(5, 8, 0, 0, 0, 0);
    pulse_start(0);
    exp_w = '{5, 6, 7, 8};
    run_seq("degen", 1, 1);

    // single-word sweeps
    cfg(7, 7, 3, 2, 1, 0);
    pulse_start(0);
    exp_w = '{7};
    run_seq("one", 2, 1);
    cfg(7, 7, 3, 2, 1, 1);
    pulse_start(0);
    exp_w = '{7, 7, 7};
    run_seq("one cont", 2, 0);
    chk("one cont dir", dir, 0);
    pulse_abort();
    @(negedge clk_wave);
    chk("one cont abort busy", busy, 0);

    // asynchronous reset mid-sweep
    cfg(5, 8, 0, 0, 0, 0);
    pulse_start(0);
    exp_w = '{5, 6};
    run_seq("arst", 1, 0);
    #1;
    sys_rst = 1'b0;
    #1;
    chk("arst word", freq_word, 0);
    chk("arst valid", freq_valid, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    repeat (2) @(negedge clk_wave);
    chk("arst hold done", done, 0);
    sys_rst = 1'b1;
    @(negedge clk_wave);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Programmable frequency-sweep sequencer that generates the frequency tuning word consumed by the DDS phase accumulator. It replaces a free-running sweep counter with a start/stop-bounded, step-sized, dwell-timed sweep, in either sawtooth or triangle mode, single-shot or continuous. It runs entirely in the waveform clock domain, so the tuning word changes synchronously with phase accumulation.

## Interface
- FW, 14: tuning-word width, equal to the DDS phase-accumulator width.
- DW, 24: dwell-counter width.

- clk_wave  in  1  waveform/DDS clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep; ignored while busy.
- abort  in  1  terminates the sweep; has priority over start.
- f_start  in  FW  first (lower) tuning word.
- f_stop  in  FW  last (upper) tuning word.
- f_step  in  FW  increment per step; 0 is treated as 1.
- dwell  in  DW  clk_wave cycles to hold each word; 0 is treated as 1.
- mode  in  1  0 = sawtooth (up only), 1 = triangle (up then down).
- cont  in  1  1 = repeat indefinitely, 0 = single pass.
- freq_word  out  FW  tuning word to the DDS.
- freq_valid  out  1  one-cycle pulse on every freq_word update.
- busy  out  1  high while a sweep is in progress.
- dir  out  1  0 = ascending, 1 = descending.
- done  out  1  one-cycle pulse when a single-pass sweep completes.
- err  out  1  one-cycle pulse when start is rejected because of bad bounds.

## Operation
- States: IDLE, RUN_UP, RUN_DN.
- Configuration (f_start, f_stop, f_step, dwell, mode, cont) is latched when start is accepted. Input changes during a sweep have no effect.
- **IDLE + start:**
  - If f_start > f_stop: assert err, stay in IDLE, leave outputs unchanged.
  - Otherwise: freq_word = f_start, freq_valid = 1, busy = 1, dir = 0, go to RUN_UP, load the dwell counter.
- **Dwell:** every word is held for exactly max(dwell,1) cycles, counted from its freq_valid cycle. The step happens on the final dwell cycle.
- **RUN_UP step:** compute next = freq_word + step as an FW+1-bit value, where step = max(f_step,1).
  - If freq_word < f_stop: freq_word = min(next, f_stop).
  - If freq_word == f_stop (end of ascent):
    - mode 0, cont 1: reload f_start.
    - mode 0, cont 0: done pulse, go to IDLE.
    - mode 1: dir = 1, go to RUN_DN and apply the down step immediately. f_stop is not held twice.
- **RUN_DN step:** next = freq_word − step, computed with borrow detection.
  - If freq_word > f_start: freq_word = max(next, f_start). Borrow counts as below f_start.
  - If freq_word == f_start (end of descent):
    - cont 1: dir = 0, go to RUN_UP and step up.
    - cont 0: done pulse, go to IDLE.
- **Degenerate case f_start == f_stop:** hold the single word for one dwell.
  - cont 0: done.
  - cont 1: reload the same word and pulse freq_valid every dwell.
- **Leaving the sweep:** on done or abort, go to IDLE and set freq_word = 0, busy = 0, dir = 0. freq_valid pulses when freq_word changes to 0.
- **Start/abort interactions:**
  - abort in IDLE: no effect.
  - start and abort in the same cycle: abort wins, and start is dropped.

## Timing
- Reset values: freq_word = 0, freq_valid = 0, busy = 0, dir = 0, done = 0, err = 0, state = IDLE, dwell counter = 0.
- Reset asserted mid-sweep returns to reset values immediately, with no done pulse.
- All outputs are registered.
- start sampled at edge N:
  - freq_word = f_start and freq_valid = 1 in cycle N+1.
  - Next update (freq_valid) in cycle N+1+max(dwell,1).
- err is visible in the cycle after the rejected start.
- done and the return to freq_word = 0 occur together, exactly max(dwell,1) cycles after the last word's freq_valid.
- abort sampled at edge N: busy = 0 and freq_word = 0 in cycle N+1.
- start is accepted again from the first cycle in which busy = 0.
- freq_valid, done and err are never high for more than one consecutive cycle. The exception is dwell ≤ 1, where freq_valid is high every cycle.

## Test plan
- **Sawtooth single-pass:** f_start = 10, f_stop = 40, f_step = 10, dwell = 3, mode 0, cont 0 -> words 10, 20, 30, 40, each held 3 cycles. done then follows 3 cycles after 40, with freq_word = 0 and busy = 0.
- **Clamp and triangle:** f_start = 100, f_stop = 125, f_step = 10, dwell = 1, mode 1, cont 0 -> words 100, 110, 120, 125, 115, 105, 100. dir rises on 115. done follows.
- **Continuous wrap at full scale:** f_start = 16380, f_stop = 16383, f_step = 2, dwell = 2, mode 0, cont 1 -> words 16380, 16382, 16383, 16380, … with no overflow. busy stays 1.
- **Bad bounds:** f_start = 50, f_stop = 20, start -> err pulse for one cycle. busy stays 0 and freq_word stays 0.
- **Abort and priority:** abort mid-dwell at word 30 -> next cycle freq_word = 0, busy = 0, no done. Then start and abort in the same cycle -> sweep does not begin.
- **Degenerate parameters:** f_step = 0, dwell = 0, f_start = 5, f_stop = 8, mode 0, cont 0 -> words 5, 6, 7, 8 on consecutive cycles, with done the cycle after 8. Asserting sys_rst mid-sweep -> all outputs return to 0 immediately.
